// File: rtl/de10lite_hex_pkg.sv
// de10lite_hex_pkg: shared states and segment constants for the DE10-Lite hex sequencer
package de10lite_hex_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, WR10, WR32, WR54} state_e;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [127:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };
  function automatic logic [7:0] seg_code(input logic [3:0] n);
    return SEG_TABLE[{n, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/hex_seg_decode.sv
// hex_seg_decode: nibble plus blank/dp to active-low seven-segment byte
module hex_seg_decode
  import de10lite_hex_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);
  // table entries have bit7 set, so masking it with ~dp lights the point
  assign seg_o = blank_i ? SEG_BLANK : (seg_code(nibble_i) & {~dp_i, 7'h7F});
endmodule

// File: rtl/de10lite_hex_sequencer.sv
// de10lite_hex_sequencer: decodes hex requests and writes only changed HEX PIO words over Avalon-MM
module de10lite_hex_sequencer
  import de10lite_hex_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] HEX10_ADDR = 'h0000,
  parameter logic [ADDR_W-1:0] HEX32_ADDR = 'h0010,
  parameter logic [ADDR_W-1:0] HEX54_ADDR = 'h0020
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [23:0]       req_value,
  input  logic [5:0]        req_blank,
  input  logic [5:0]        req_dp,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  output logic              busy
);
  state_e            state_q, nxt_d;
  logic              pend_q;
  logic [23:0]       pend_value_q;
  logic [5:0]        pend_blank_q, pend_dp_q;
  logic [7:0]        dec_byte[6];
  logic [15:0]       dec_word[3], word_q[3], shadow_q[3];
  logic              write_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic [1:0]        cur, nxt_idx;
  logic [2:0]        dirty;
  logic              step;

  for (genvar d = 0; d < 6; d++) begin : g_dec
    hex_seg_decode u_dec (
      .nibble_i(pend_value_q[4*d +: 4]),
      .blank_i (pend_blank_q[d]),
      .dp_i    (pend_dp_q[d]),
      .seg_o   (dec_byte[d])
    );
  end
  for (genvar w = 0; w < 3; w++) begin : g_word
    assign dec_word[w] = {dec_byte[2*w+1], dec_byte[2*w]};
  end

  // choose the next word that differs from its shadow, in HEX10/32/54 order
  always_comb begin
    cur = state_q == WR32 ? 2'd1 : state_q == WR54 ? 2'd2 : 2'd0;
    for (int i = 0; i < 3; i++)
      dirty[i] = state_q == LOAD ? dec_word[i] != shadow_q[i]
                                 : (word_q[i] != shadow_q[i]) && (2'(i) > cur);
    nxt_idx = dirty[0] ? 2'd0 : dirty[1] ? 2'd1 : 2'd2;
    nxt_d   = dirty[0] ? WR10 : dirty[1] ? WR32 : dirty[2] ? WR54 : IDLE;
    addr_d  = nxt_d == IDLE ? '0 : nxt_idx == 2'd0 ? HEX10_ADDR : nxt_idx == 2'd1 ? HEX32_ADDR : HEX54_ADDR;
    data_d  = nxt_d == IDLE ? '0 : state_q == LOAD ? dec_word[nxt_idx] : word_q[nxt_idx];
    step    = state_q == LOAD || (write_q && !avm_waitrequest);
  end

  // request latch, sequencing FSM, shadows and registered master outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pend_q       <= 1'b0;
      pend_value_q <= '0;
      pend_blank_q <= '0;
      pend_dp_q    <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      for (int i = 0; i < 3; i++) begin
        word_q[i]   <= 16'hFFFF;
        shadow_q[i] <= 16'hFFFF;
      end
    end else begin
      if (req_valid && !pend_q) begin
        pend_q       <= 1'b1;
        pend_value_q <= req_value;
        pend_blank_q <= req_blank;
        pend_dp_q    <= req_dp;
      end
      if (state_q == IDLE && pend_q) begin
        pend_q  <= 1'b0;
        state_q <= LOAD;
      end
      if (state_q == LOAD)
        for (int i = 0; i < 3; i++) word_q[i] <= dec_word[i];
      if (write_q && !avm_waitrequest) shadow_q[cur] <= word_q[cur];
      if (step) begin
        state_q <= nxt_d;
        write_q <= nxt_d != IDLE;
        addr_q  <= addr_d;
        data_q  <= data_d;
      end
    end
  end

  assign req_ready     = ~pend_q;
  assign busy          = state_q != IDLE;
  assign avm_write     = write_q;
  assign avm_address   = addr_q;
  assign avm_writedata = {16'h0000, data_q};
endmodule

// File: tb/tb_de10lite_hex_sequencer.sv
// tb_de10lite_hex_sequencer: directed self-checking bench for the hex sequencer
module tb_de10lite_hex_sequencer;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_value = '0;
  logic [5:0]  req_blank = '0;
  logic [5:0]  req_dp = '0;
  logic [15:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest = 1'b0;
  logic        busy;

  int total = 0;
  int bad = 0;
  int busy_cnt = 0;
  logic [15:0] log_a[$];
  logic [31:0] log_d[$];
  logic [31:0] pio[3];

  de10lite_hex_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_value(req_value), .req_blank(req_blank), .req_dp(req_dp),
    .avm_address(avm_address), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .busy(busy)
  );

  always #5 clk = ~clk;

  // bus monitor: logs accepted writes, models PIO contents, counts busy cycles
  always @(posedge clk) begin
    if (reset_n && avm_write && !avm_waitrequest) begin
      log_a.push_back(avm_address);
      log_d.push_back(avm_writedata);
      if (avm_address[5:4] != 2'd3) pio[avm_address[5:4]] = avm_writedata;
    end
    if (reset_n && busy) busy_cnt++;
  end

  task automatic clear_log();
    log_a.delete();
    log_d.delete();
    busy_cnt = 0;
  endtask

  task automatic send(input logic [23:0] v, input logic [5:0] b, input logic [5:0] d, output int waited);
    req_value = v;
    req_blank = b;
    req_dp = d;
    req_valid = 1'b1;
    waited = 0;
    while (!req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (!req_ready) begin
      bad++;
      $display("FAIL send_ready: req_ready=%b required 1 within 100 cycles", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || !req_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (busy || !req_ready) begin
      bad++;
      $display("FAIL wait_idle: busy=%b req_ready=%b after 200 cycles", busy, req_ready);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total += 5;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    if (avm_write !== 1'b0) begin bad++; $display("FAIL rst_write: got %b want 0", avm_write); end
    if (avm_address !== 16'h0) begin bad++; $display("FAIL rst_addr: got %h want 0000", avm_address); end
    if (avm_writedata !== 32'h0) begin bad++; $display("FAIL rst_data: got %h want 0", avm_writedata); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) pio[i] = 32'h0000FFFF;
    @(negedge clk);
  endtask

  task automatic test_all_blank();
    int w;
    clear_log();
    send(24'h000000, 6'h3F, 6'h00, w);
    wait_idle();
    total += 2;
    if (log_a.size() != 0) begin bad++; $display("FAIL blank_writes: got %0d want 0", log_a.size()); end
    if (busy_cnt != 1) begin bad++; $display("FAIL blank_busy: got %0d want 1", busy_cnt); end
  endtask

  task automatic test_full_update();
    int w;
    logic [15:0] ea[3];
    logic [31:0] ed[3];
    ea = '{16'h0000, 16'h0010, 16'h0020};
    ed = '{32'h0000F9C0, 32'h0000B0A4, 32'h00009299};
    clear_log();
    send(24'h543210, 6'h00, 6'h00, w);
    wait_idle();
    total += 2;
    if (log_a.size() != 3) begin bad++; $display("FAIL full_count: got %0d want 3", log_a.size()); end
    if (busy_cnt != 4) begin bad++; $display("FAIL full_busy: got %0d want 4", busy_cnt); end
    for (int i = 0; i < 3 && i < log_a.size(); i++) begin
      total++;
      if (log_a[i] !== ea[i] || log_d[i] !== ed[i]) begin
        bad++;
        $display("FAIL full_wr%0d: got %h/%h want %h/%h", i, log_a[i], log_d[i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_change_only();
    int w;
    clear_log();
    send(24'h543210, 6'h00, 6'h00, w);
    wait_idle();
    total += 2;
    if (log_a.size() != 0) begin bad++; $display("FAIL repeat_count: got %0d want 0", log_a.size()); end
    if (busy_cnt != 1) begin bad++; $display("FAIL repeat_busy: got %0d want 1", busy_cnt); end
    clear_log();
    send(24'h54321F, 6'h00, 6'h00, w);
    wait_idle();
    total += 3;
    if (log_a.size() != 1) begin bad++; $display("FAIL one_count: got %0d want 1", log_a.size()); end
    else if (log_a[0] !== 16'h0000 || log_d[0] !== 32'h0000F98E) begin
      bad++; $display("FAIL one_wr: got %h/%h want 0000/0000f98e", log_a[0], log_d[0]);
    end
    if (busy_cnt != 2) begin bad++; $display("FAIL one_busy: got %0d want 2", busy_cnt); end
  endtask

  task automatic test_dp_blank();
    int w;
    clear_log();
    send(24'h543210, 6'h02, 6'h03, w);
    wait_idle();
    total++;
    if (log_a.size() != 1 || log_a[0] !== 16'h0000 || log_d[0] !== 32'h0000FF40) begin
      bad++;
      $display("FAIL dp_blank: got n=%0d %h want n=1 0000/0000ff40", log_a.size(),
               log_d.size() > 0 ? log_d[0] : 32'hx);
    end
  endtask

  task automatic test_waitrequest();
    int w;
    int n = 0;
    clear_log();
    avm_waitrequest = 1'b1;
    send(24'h543211, 6'h00, 6'h00, w);
    while (!avm_write && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (avm_write !== 1'b1 || avm_address !== 16'h0000 || avm_writedata !== 32'h0000F9F9) begin
        bad++;
        $display("FAIL stall_c%0d: got %b %h %h want 1 0000 0000f9f9", k, avm_write, avm_address, avm_writedata);
      end
      if (k == 2) begin
        total++;
        if (log_a.size() != 0) begin bad++; $display("FAIL stall_early: got %0d writes want 0", log_a.size()); end
      end
      if (k == 3) avm_waitrequest = 1'b0;
      @(negedge clk);
    end
    total += 2;
    if (avm_write !== 1'b0) begin bad++; $display("FAIL stall_drop: got %b want 0", avm_write); end
    if (log_a.size() != 1) begin bad++; $display("FAIL stall_count: got %0d want 1", log_a.size()); end
    wait_idle();
    clear_log();
    send(24'h543211, 6'h00, 6'h00, w);
    wait_idle();
    total++;
    if (log_a.size() != 0) begin bad++; $display("FAIL stall_shadow: got %0d writes want 0", log_a.size()); end
  endtask

  task automatic test_back_to_back();
    int wa, wb, wc;
    logic [15:0] ea[8];
    logic [31:0] ed[8];
    ea = '{16'h10, 16'h20, 16'h00, 16'h10, 16'h20, 16'h00, 16'h10, 16'h20};
    ed = '{32'hF9F9, 32'hF9F9, 32'hA4A4, 32'hA4A4, 32'hA4A4, 32'hB0B0, 32'hB0B0, 32'hB0B0};
    clear_log();
    send(24'h111111, 6'h00, 6'h00, wa);
    send(24'h222222, 6'h00, 6'h00, wb);
    send(24'h333333, 6'h00, 6'h00, wc);
    wait_idle();
    total += 2;
    if (wc < 1) begin bad++; $display("FAIL b2b_c_wait: got %0d cycles want >=1", wc); end
    if (log_a.size() != 8) begin bad++; $display("FAIL b2b_count: got %0d want 8", log_a.size()); end
    for (int i = 0; i < 8 && i < log_a.size(); i++) begin
      total++;
      if (log_a[i] !== ea[i] || log_d[i] !== ed[i]) begin
        bad++;
        $display("FAIL b2b_wr%0d: got %h/%h want %h/%h", i, log_a[i], log_d[i], ea[i], ed[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (pio[i] !== 32'h0000B0B0) begin bad++; $display("FAIL b2b_pio%0d: got %h want 0000b0b0", i, pio[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int w;
    int n = 0;
    send(24'h444444, 6'h00, 6'h00, w);
    while (!(avm_write && avm_address == 16'h0010) && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!(avm_write && avm_address == 16'h0010)) begin bad++; $display("FAIL mid_reach: WR32 not seen, addr=%h", avm_address); end
    #2 reset_n = 1'b0;
    #1;
    total += 3;
    if (avm_write !== 1'b0) begin bad++; $display("FAIL mid_write: got %b want 0", avm_write); end
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
    if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b want 1", req_ready); end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) pio[i] = 32'h0000FFFF;
    clear_log();
    send(24'h123456, 6'h3F, 6'h00, w);
    wait_idle();
    total++;
    if (log_a.size() != 0) begin bad++; $display("FAIL post_blank: got %0d writes want 0", log_a.size()); end
    clear_log();
    send(24'h000000, 6'h00, 6'h00, w);
    wait_idle();
    total++;
    if (log_a.size() != 3) begin bad++; $display("FAIL post_count: got %0d want 3", log_a.size()); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (pio[i] !== 32'h0000C0C0) begin bad++; $display("FAIL post_pio%0d: got %h want 0000c0c0", i, pio[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_all_blank();
    test_full_update();
    test_change_only();
    test_dp_blank();
    test_waitrequest();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1);
  end
endmodule

// File: doc/de10lite_hex_sequencer.md
# de10lite_hex_sequencer

Hardware controller for the six DE10-Lite seven-segment digits. It accepts a 24-bit hex value with per-digit blank and decimal-point masks, and decodes each nibble to active-low segment codes. It then sequences Avalon-MM writes into the three 16-bit hex PIO slaves (HEX1/0, HEX3/2, HEX5/4), writing only those PIO words whose content changed. It sits beside the CPU as a second Avalon-MM master on the SOPC interconnect.

## Interface
- `HEX10_ADDR`, default 16'h0000: byte address of the HEX1/0 PIO data register.
- `HEX32_ADDR`, default 16'h0010: byte address of the HEX3/2 PIO data register.
- `HEX54_ADDR`, default 16'h0020: byte address of the HEX5/4 PIO data register.
- `ADDR_W`, default 16: master address width.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request strobe.
- `req_ready` out 1: request accept.
- `req_value` in 24: nibble n drives digit HEXn.
- `req_blank` in 6: bit n=1 blanks HEXn.
- `req_dp` in 6: bit n=1 lights the HEXn decimal point.
- `avm_address` out ADDR_W: write byte address.
- `avm_write` out 1: write strobe.
- `avm_writedata` out 32: write data, bits [31:16] are 0.
- `avm_waitrequest` in 1: slave stall.
- `busy` out 1: sequence in progress.

## Operation
- Digit byte, active-low: bits [6:0] = segments g..a, bit7 = dp (0 = lit).
- Nibble codes, 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
- Blank digit: byte = FF; blank overrides dp.
- PIO word layout: [7:0] = even digit, [15:8] = odd digit.
- Request handshake:
  - Accepted when `req_valid & req_ready`; latched into a one-deep pending register.
  - `req_ready = ~pending_valid`.
- States:
  - IDLE: if pending_valid, go to LOAD and clear pending_valid.
  - LOAD: register the three decoded words. Then go to the first of WR10, WR32, WR54 whose word differs from its shadow, or to IDLE if none differ.
  - WRn: assert `avm_write` with constant address and data until a cycle with `avm_waitrequest=0`. On that edge, update shadow n and go to the next differing WR state, or IDLE.
- Shadows reset to 16'hFFFF, matching the PIO reset value, so an all-blank request issues no writes.
- A new request may be accepted while WRn is active. It is processed only after return to IDLE; the in-flight sequence completes with the old words.
- `busy` = state != IDLE.
- `avm_write` is never asserted outside WRn.

## Timing
- Reset values: `req_ready=1`, `avm_write=0`, `avm_address=0`, `avm_writedata=0`, `busy=0`, state IDLE, pending_valid=0.
- Handshake at edge E0 → IDLE→LOAD at E1; `req_ready` is high again after E1 → first write asserted in the cycle after E2.
- With `avm_waitrequest=0`, each write takes 1 cycle. Full 3-word update: `busy` high for 4 cycles (E1..E5); return to IDLE at E5.
- A pending request waiting in IDLE enters LOAD on the following edge; there is no idle bubble beyond one cycle.
- Reset mid-write: `avm_write` drops asynchronously, shadows return to FFFF and the pending request is discarded. This is consistent because the PIOs share `reset_n`.

## Structure
- Package `de10lite_hex_pkg`:
  - state enum (IDLE, LOAD, WR10, WR32, WR54);
  - `SEG_BLANK = 8'hFF`;
  - the 16-entry segment constant table.
- Sub-module `hex_seg_decode`: nibble + blank + dp → 8-bit digit byte, purely combinational. Instantiated 6 times in LOAD-path logic.
- Top: handshake/pending register, FSM, shadows, master outputs.

## Test plan
- After reset, request value 000000, blank 3F, dp 00 → zero writes, `busy` high exactly 1 cycle (LOAD).
- Value 543210, blank 00, dp 00, no waitrequest → writes in order: HEX10_ADDR data F9C0, HEX32_ADDR data B0A4, HEX54_ADDR data 9299; `busy` 4 cycles.
- Repeat the same request, then value 54321F → only one write, HEX10_ADDR data F98E.
- `avm_waitrequest` held high 3 cycles on the first write → address and data stable through all 4 cycles; shadow updates only on the accept edge.
- Two back-to-back requests A then B while sequencing, third request C while B is pending → `req_ready` is low for C until B is loaded. All three are eventually written in order, and final PIO contents equal C.
- Assert `reset_n` low during WR32 → `avm_write` drops immediately. A post-reset request with blank 3F produces no writes.
